mem_bus_monitor: RTL and testbench
==================================

Name: mem_bus_monitor

Overview:
- Synthesizable run controller and bus monitor for the processor's data-memory bus.
- Replaces open-ended halt polling with a parametrised block that:
  - detects program completion at a configurable halt address;
  - enforces a cycle-budget watchdog;
  - counts cycles and writes;
  - buffers every store (address and data) in a FIFO so a host or bench can drain them.
- Sits beside the RAM and taps the same Mem_Address, Mem_WriteEnable and Mem_DataOut nets.

Parameters:
- ADDR_WIDTH, 32, width of the monitored address bus.
- DATA_WIDTH, 32, width of the monitored write-data bus.
- HALT_ADDR, 32'h00003ffc, address that marks program completion.
- CNT_WIDTH, 32, width of the cycle and write counters and of the timeout limit.
- LOG_DEPTH, 16, store-log FIFO entries; must be a power of two and at least 2.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  one-cycle pulse; begins a run.
- TimeoutLimit  in  CNT_WIDTH  cycle budget, sampled on Start; 0 disables the watchdog.
- Mem_Address  in  ADDR_WIDTH  processor data address.
- Mem_WriteEnable  in  1  processor store strobe.
- Mem_DataOut  in  DATA_WIDTH  processor store data.
- LogPop  in  1  dequeue the head log entry.
- Running  out  1  FSM is in RUN.
- Halted  out  1  FSM is in HALT (sticky).
- TimedOut  out  1  FSM is in TIMEOUT (sticky).
- CycleCount  out  CNT_WIDTH  cycles spent in RUN.
- WriteCount  out  CNT_WIDTH  stores observed in RUN, including dropped ones.
- LogValid  out  1  FIFO is not empty.
- LogAddress  out  ADDR_WIDTH  head entry address.
- LogData  out  DATA_WIDTH  head entry data.
- LogOverflow  out  1  sticky flag: at least one store was dropped because the FIFO was full.

Behaviour:
- Reset (Reset==0 at a rising edge):
  - FSM goes to IDLE.
  - All outputs are 0; counters are 0; FIFO pointers are 0.
  - Reset takes priority over every other input, including during RUN. The run is abandoned and logged entries are discarded.
- FSM states: IDLE, RUN, HALT, TIMEOUT.
  - IDLE -> RUN on Start. On the same edge:
    - clear CycleCount, WriteCount, LogOverflow and the FIFO;
    - latch TimeoutLimit.
  - RUN, evaluated in this priority order each cycle:
    1. Mem_Address==HALT_ADDR: go to HALT.
    2. Latched limit != 0 and CycleCount+1 == limit: go to TIMEOUT.
    3. Otherwise stay in RUN.
  - If halt and timeout coincide on the same cycle, HALT wins.
  - HALT and TIMEOUT -> RUN on Start, with the same clearing as above. Otherwise they hold.
  - Start while in RUN is ignored.
- CycleCount:
  - Increments on every RUN cycle, including the exit cycle.
  - Saturates at all-ones and never wraps.
  - Frozen in HALT and TIMEOUT.
- Store capture (RUN only):
  - Every RUN cycle with Mem_WriteEnable==1 increments WriteCount (saturating).
  - The pair {Mem_Address, Mem_DataOut} is pushed into the FIFO.
  - A store on the halt-detect cycle is still captured.
  - Stores outside RUN are ignored.
- FIFO:
  - First-word-fall-through: LogAddress and LogData show the head entry whenever LogValid is set.
  - A push becomes visible on LogValid on the next cycle.
  - LogPop with LogValid==0 is ignored.
  - Push while full: the entry is dropped and LogOverflow is set. Existing entries are untouched.
  - Push and pop on the same cycle while full: the pop frees a slot, so the push is accepted and no overflow occurs.
  - Push and pop on the same cycle while empty: the pop is ignored and the push is accepted.
  - Pointers are log2(LOG_DEPTH)+1 bits wide, with natural wrap.
  - The FIFO remains drainable in HALT, TIMEOUT and IDLE.
- Running, Halted and TimedOut are registered; each reflects the current state.

Test Plan:
- Reset low for 2 cycles mid-run (CycleCount=5, 3 log entries) -> all outputs 0 on the next cycle and LogValid=0; Start is then accepted normally.
- Start with TimeoutLimit=0; stores to 0x10/0xAA and 0x14/0xBB; Mem_Address=0x3ffc on RUN cycle 6 -> Halted=1, CycleCount=6, WriteCount=2; pops return (0x10,0xAA) then (0x14,0xBB); then LogValid=0.
- TimeoutLimit=4, address never 0x3ffc -> TimedOut=1 after the 4th RUN cycle, CycleCount=4, Running=0.
- TimeoutLimit=3 with 0x3ffc on RUN cycle 3 -> Halted=1, TimedOut=0.
- LOG_DEPTH=4: 6 consecutive stores, no pops -> WriteCount=6, LogOverflow=1, FIFO holds stores 1–4 in order. A second run with a simultaneous push and pop while full -> LogOverflow stays 0.
- Start from HALT -> counters, LogOverflow and FIFO cleared, Running=1; Start held during RUN has no effect.

Source files
------------

// File: rtl/mem_bus_monitor.sv
`timescale 1ns/1ps
// Run controller and store logger for the data-memory bus: halt/timeout FSM, cycle/write counters, FWFT store FIFO.
// Status and log head change one cycle after the sampled bus cycle; a store into a full log is dropped and flagged, never stalled.
module mem_bus_monitor #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR  = 32'h00003ffc,
    parameter int                    CNT_WIDTH  = 32,
    parameter int                    LOG_DEPTH  = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [CNT_WIDTH-1:0]  TimeoutLimit,
    input  logic [ADDR_WIDTH-1:0] Mem_Address,
    input  logic                  Mem_WriteEnable,
    input  logic [DATA_WIDTH-1:0] Mem_DataOut,
    input  logic                  LogPop,
    output logic                  Running,
    output logic                  Halted,
    output logic                  TimedOut,
    output logic [CNT_WIDTH-1:0]  CycleCount,
    output logic [CNT_WIDTH-1:0]  WriteCount,
    output logic                  LogValid,
    output logic [ADDR_WIDTH-1:0] LogAddress,
    output logic [DATA_WIDTH-1:0] LogData,
    output logic                  LogOverflow
);

    localparam int IDX_W = $clog2(LOG_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_TIMEOUT} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] dat;
    } log_entry_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   limit_q, limit_d;
    logic [CNT_WIDTH-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_WIDTH-1:0]   write_cnt_q, write_cnt_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic                   overflow_q, overflow_d;
    log_entry_t             log_mem_q [LOG_DEPTH];

    logic                   in_run;
    logic                   start_run;
    logic                   store_vld;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   pop_ok;
    logic                   push_ok;
    logic [CNT_WIDTH:0]     cycle_next;
    log_entry_t             head;

    assign in_run     = (state_q == S_RUN);
    assign start_run  = Start && !in_run;
    assign store_vld  = in_run && Mem_WriteEnable;
    // One extra bit so an all-ones count can never alias a small limit.
    assign cycle_next = {1'b0, cycle_cnt_q} + (CNT_WIDTH+1)'(1);

    // State register and all sequential datapath state.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            limit_q     <= '0;
            cycle_cnt_q <= '0;
            write_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            limit_q     <= limit_d;
            cycle_cnt_q <= cycle_cnt_d;
            write_cnt_q <= write_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
        end
    end

    // Log storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge Clock) begin
        if (push_ok) begin
            log_mem_q[wr_ptr_q[IDX_W-1:0]] <= '{addr: Mem_Address, dat: Mem_DataOut};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT, S_TIMEOUT: begin
                if (Start) state_d = S_RUN;
            end
            S_RUN: begin
                if (Mem_Address == HALT_ADDR) begin
                    state_d = S_HALT;
                end else if ((limit_q != '0) && (cycle_next == {1'b0, limit_q})) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
        pop_ok     = LogPop && !fifo_empty;
        // A same-cycle pop frees the slot the push needs.
        push_ok    = store_vld && (!fifo_full || pop_ok);

        limit_d     = limit_q;
        cycle_cnt_d = cycle_cnt_q;
        write_cnt_d = write_cnt_q;
        wr_ptr_d    = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_ok);
        overflow_d  = overflow_q || (store_vld && !push_ok);

        if (start_run) begin
            limit_d     = TimeoutLimit;
            cycle_cnt_d = '0;
            write_cnt_d = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
        end else if (in_run) begin
            if (cycle_cnt_q != '1) cycle_cnt_d = cycle_next[CNT_WIDTH-1:0];
            if (store_vld && (write_cnt_q != '1)) write_cnt_d = write_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        head        = log_mem_q[rd_ptr_q[IDX_W-1:0]];
        Running     = (state_q == S_RUN);
        Halted      = (state_q == S_HALT);
        TimedOut    = (state_q == S_TIMEOUT);
        CycleCount  = cycle_cnt_q;
        WriteCount  = write_cnt_q;
        LogValid    = !fifo_empty;
        LogAddress  = fifo_empty ? '0 : head.addr;
        LogData     = fifo_empty ? '0 : head.dat;
        LogOverflow = overflow_q;
    end

endmodule

// File: tb/tb_mem_bus_monitor.sv
`timescale 1ns/1ps
// Directed bench for mem_bus_monitor with a 4-entry log: table of per-cycle vectors plus hand-built overflow and reset sequences.
module tb_mem_bus_monitor;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [31:0] TimeoutLimit;
    logic [31:0] Mem_Address;
    logic        Mem_WriteEnable;
    logic [31:0] Mem_DataOut;
    logic        LogPop;
    logic        Running;
    logic        Halted;
    logic        TimedOut;
    logic [31:0] CycleCount;
    logic [31:0] WriteCount;
    logic        LogValid;
    logic [31:0] LogAddress;
    logic [31:0] LogData;
    logic        LogOverflow;

    int checks;
    int failures;

    mem_bus_monitor #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .HALT_ADDR  (32'h00003ffc),
        .CNT_WIDTH  (32),
        .LOG_DEPTH  (4)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Start           (Start),
        .TimeoutLimit    (TimeoutLimit),
        .Mem_Address     (Mem_Address),
        .Mem_WriteEnable (Mem_WriteEnable),
        .Mem_DataOut     (Mem_DataOut),
        .LogPop          (LogPop),
        .Running         (Running),
        .Halted          (Halted),
        .TimedOut        (TimedOut),
        .CycleCount      (CycleCount),
        .WriteCount      (WriteCount),
        .LogValid        (LogValid),
        .LogAddress      (LogAddress),
        .LogData         (LogData),
        .LogOverflow     (LogOverflow)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        st;
        logic [31:0] lim;
        logic [31:0] ad;
        logic        we;
        logic [31:0] dt;
        logic        pop;
        logic        e_run;
        logic        e_halt;
        logic        e_to;
        logic [31:0] e_cyc;
        logic [31:0] e_wc;
        logic        e_lv;
        logic [31:0] e_la;
        logic [31:0] e_ld;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int st, input int lim, input int ad, input int we,
                                input int dt, input int pop, input int run, input int halt,
                                input int to, input int cyc, input int wc, input int lv,
                                input int la, input int ld, input int ovf);
        vec_t v;
        v.st = (st != 0);     v.lim = lim;          v.ad = ad;
        v.we = (we != 0);     v.dt = dt;            v.pop = (pop != 0);
        v.e_run = (run != 0); v.e_halt = (halt != 0); v.e_to = (to != 0);
        v.e_cyc = cyc;        v.e_wc = wc;          v.e_lv = (lv != 0);
        v.e_la = la;          v.e_ld = ld;          v.e_ovf = (ovf != 0);
        return v;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [31:0] lim, input logic [31:0] ad,
                         input logic we, input logic [31:0] dt, input logic pop);
        Start = st; TimeoutLimit = lim; Mem_Address = ad;
        Mem_WriteEnable = we; Mem_DataOut = dt; LogPop = pop;
    endtask

    task automatic check_outputs(input string tag, input logic run, input logic halt,
                                 input logic to, input logic [31:0] cyc, input logic [31:0] wc,
                                 input logic lv, input logic [31:0] la, input logic [31:0] ld,
                                 input logic ovf);
        chk({tag, ".running"},  32'(Running),     32'(run));
        chk({tag, ".halted"},   32'(Halted),      32'(halt));
        chk({tag, ".timedout"}, 32'(TimedOut),    32'(to));
        chk({tag, ".cycles"},   CycleCount,       cyc);
        chk({tag, ".writes"},   WriteCount,       wc);
        chk({tag, ".logvalid"}, 32'(LogValid),    32'(lv));
        chk({tag, ".logaddr"},  LogAddress,       la);
        chk({tag, ".logdata"},  LogData,          ld);
        chk({tag, ".overflow"}, 32'(LogOverflow), 32'(ovf));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Clock    = 1'b0;
        Reset    = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Halt run with two stores, then drain; TimeoutLimit=0 disables the watchdog.
        vecs.push_back(mk(1, 0, 0,      0, 0,    0, 1, 0, 0, 0, 0, 0, 0,    0,    0));
        vecs.push_back(mk(0, 0, 'h10,   1, 'hAA, 0, 1, 0, 0, 1, 1, 1, 'h10, 'hAA, 0));
        vecs.push_back(mk(0, 0, 'h14,   1, 'hBB, 0, 1, 0, 0, 2, 2, 1, 'h10, 'hAA, 0));
        vecs.push_back(mk(0, 0, 'h20,   0, 'h55, 0, 1, 0, 0, 3, 2, 1, 'h10, 'hAA, 0));
        vecs.push_back(mk(0, 0, 'h24,   0, 0,    0, 1, 0, 0, 4, 2, 1, 'h10, 'hAA, 0));
        vecs.push_back(mk(0, 0, 'h28,   0, 0,    0, 1, 0, 0, 5, 2, 1, 'h10, 'hAA, 0));
        vecs.push_back(mk(0, 0, 'h3ffc, 0, 0,    0, 0, 1, 0, 6, 2, 1, 'h10, 'hAA, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0,    0, 0, 1, 0, 6, 2, 1, 'h10, 'hAA, 0));
        vecs.push_back(mk(0, 0, 'h30,   1, 'hCC, 0, 0, 1, 0, 6, 2, 1, 'h10, 'hAA, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0,    1, 0, 1, 0, 6, 2, 1, 'h14, 'hBB, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0,    1, 0, 1, 0, 6, 2, 0, 0,    0,    0));
        vecs.push_back(mk(0, 0, 0,      0, 0,    1, 0, 1, 0, 6, 2, 0, 0,    0,    0));
        // Watchdog at 4 cycles; a Start (with a new limit) mid-run must be ignored.
        vecs.push_back(mk(1, 4, 'h100,  0, 0,    0, 1, 0, 0, 0, 0, 0, 0,    0,    0));
        vecs.push_back(mk(0, 4, 'h100,  0, 0,    0, 1, 0, 0, 1, 0, 0, 0,    0,    0));
        vecs.push_back(mk(1, 9, 'h104,  0, 0,    0, 1, 0, 0, 2, 0, 0, 0,    0,    0));
        vecs.push_back(mk(0, 4, 'h108,  0, 0,    0, 1, 0, 0, 3, 0, 0, 0,    0,    0));
        vecs.push_back(mk(0, 4, 'h10c,  0, 0,    0, 0, 0, 1, 4, 0, 0, 0,    0,    0));
        vecs.push_back(mk(0, 4, 0,      0, 0,    0, 0, 0, 1, 4, 0, 0, 0,    0,    0));
        // Halt and timeout on the same cycle: halt wins.
        vecs.push_back(mk(1, 3, 0,      0, 0,    0, 1, 0, 0, 0, 0, 0, 0,    0,    0));
        vecs.push_back(mk(0, 0, 0,      0, 0,    0, 1, 0, 0, 1, 0, 0, 0,    0,    0));
        vecs.push_back(mk(0, 0, 0,      0, 0,    0, 1, 0, 0, 2, 0, 0, 0,    0,    0));
        vecs.push_back(mk(0, 0, 'h3ffc, 0, 0,    0, 0, 1, 0, 3, 0, 0, 0,    0,    0));
        vecs.push_back(mk(0, 0, 0,      0, 0,    0, 0, 1, 0, 3, 0, 0, 0,    0,    0));

        repeat (2) tick();
        check_outputs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].lim, vecs[i].ad, vecs[i].we, vecs[i].dt, vecs[i].pop);
            tick();
            check_outputs($sformatf("vec%0d", i), vecs[i].e_run, vecs[i].e_halt, vecs[i].e_to,
                          vecs[i].e_cyc, vecs[i].e_wc, vecs[i].e_lv, vecs[i].e_la,
                          vecs[i].e_ld, vecs[i].e_ovf);
        end

        // Six stores into a 4-entry log: last two dropped, first four kept in order.
        drive(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("ovf.start.running", 32'(Running), 32'd1);
        chk("ovf.start.overflow", 32'(LogOverflow), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 32'h0, 32'h40 + 32'(4 * k), 1'b1, 32'(k), 1'b0);
            tick();
            chk($sformatf("ovf.st%0d.writes", k), WriteCount, 32'(k));
            chk($sformatf("ovf.st%0d.overflow", k), 32'(LogOverflow), (k > 4) ? 32'd1 : 32'd0);
            chk($sformatf("ovf.st%0d.headaddr", k), LogAddress, 32'h44);
        end
        drive(1'b0, 32'h0, 32'h3ffc, 1'b0, 32'h0, 1'b0);
        tick();
        chk("ovf.halt.halted", 32'(Halted), 32'd1);
        chk("ovf.halt.cycles", CycleCount, 32'd7);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf.drain%0d.valid", k), 32'(LogValid), 32'd1);
            chk($sformatf("ovf.drain%0d.addr", k), LogAddress, 32'h40 + 32'(4 * k));
            chk($sformatf("ovf.drain%0d.data", k), LogData, 32'(k));
            LogPop = 1'b1;
            tick();
        end
        LogPop = 1'b0;
        chk("ovf.drained.valid", 32'(LogValid), 32'd0);
        chk("ovf.drained.overflow_sticky", 32'(LogOverflow), 32'd1);

        // Restart from HALT clears everything; push+pop on empty and on full.
        drive(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        check_outputs("restart", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1'b0, 32'h0, 32'h44, 1'b1, 32'h1, 1'b1);
        tick();
        chk("pp_empty.valid", 32'(LogValid), 32'd1);
        chk("pp_empty.addr", LogAddress, 32'h44);
        chk("pp_empty.writes", WriteCount, 32'd1);
        for (int k = 2; k <= 4; k++) begin
            drive(1'b0, 32'h0, 32'h40 + 32'(4 * k), 1'b1, 32'(k), 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h54, 1'b1, 32'h5, 1'b1);
        tick();
        chk("pp_full.overflow", 32'(LogOverflow), 32'd0);
        chk("pp_full.writes", WriteCount, 32'd5);
        chk("pp_full.headaddr", LogAddress, 32'h48);
        drive(1'b0, 32'h0, 32'h3ffc, 1'b0, 32'h0, 1'b0);
        tick();
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("pp_drain%0d.addr", k), LogAddress, 32'h40 + 32'(4 * k));
            chk($sformatf("pp_drain%0d.data", k), LogData, 32'(k));
            LogPop = 1'b1;
            tick();
        end
        LogPop = 1'b0;
        chk("pp_drained.valid", 32'(LogValid), 32'd0);
        chk("pp_drained.overflow", 32'(LogOverflow), 32'd0);

        // Reset mid-run (with Start and a store asserted) abandons the run and the log.
        drive(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        for (int c = 1; c <= 5; c++) begin
            drive(1'b0, 32'h0, 32'h80 + 32'(4 * c), (c <= 3), 32'(c), 1'b0);
            tick();
        end
        chk("midrun.cycles", CycleCount, 32'd5);
        chk("midrun.writes", WriteCount, 32'd3);
        chk("midrun.valid", 32'(LogValid), 32'd1);
        Reset = 1'b0;
        drive(1'b1, 32'h7, 32'h90, 1'b1, 32'h9, 1'b1);
        tick();
        check_outputs("midreset1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_outputs("midreset2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        drive(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        check_outputs("post_reset_start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        Start = 1'b0;
        tick();
        chk("post_reset_run.cycles", CycleCount, 32'd1);
        chk("post_reset_run.running", 32'(Running), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
